// File: rtl/cdc_in_arbiter.sv
// cdc_in_arbiter: round-robin burst arbiter feeding one usb_cdc IN byte channel.
// Each grant optionally emits a {HDR_TAG, id} header, then up to MAX_BURST payload bytes.
// Ports:
//   clk_i, rst_i             clock, synchronous active-high reset
//   src_data_i/valid_i       SOURCES byte streams (source k on bits [8k+7:8k])
//   src_ready_o              per-source accept strobe (combinational)
//   dst_data_o/valid_o       registered byte to usb_cdc in_data/in_valid
//   dst_ready_i              usb_cdc in_ready
//   grant_o                  one-hot current grant, 0 while arbitrating
module cdc_in_arbiter #(
    parameter int          SOURCES   = 2,
    parameter int          MAX_BURST = 8,
    parameter int          HEADER_EN = 1,
    parameter logic [3:0]  HDR_TAG   = 4'hA
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic [8*SOURCES-1:0]   src_data_i,
    input  logic [SOURCES-1:0]     src_valid_i,
    output logic [SOURCES-1:0]     src_ready_o,
    output logic [7:0]             dst_data_o,
    output logic                   dst_valid_o,
    input  logic                   dst_ready_i,
    output logic [SOURCES-1:0]     grant_o
);

    localparam int CW = $clog2(MAX_BURST + 1);

    localparam logic [1:0] ST_ARB   = 2'd0;
    localparam logic [1:0] ST_HDR   = 2'd1;
    localparam logic [1:0] ST_BURST = 2'd2;

    localparam logic [CW-1:0] LAST_BYTE = CW'(MAX_BURST - 1);
    localparam logic [3:0]    LAST_SRC  = 4'(SOURCES - 1);
    localparam logic [4:0]    NSRC      = 5'(SOURCES);

    logic [1:0]    state;
    logic [3:0]    ptr;
    logic [3:0]    cur;
    logic [CW-1:0] count;

    // Zero-extended views so every index is a clean 4-bit select.
    logic [15:0]   valid16;
    logic [127:0]  data128;

    logic          free;
    logic          cur_valid;
    logic [7:0]    cur_data;
    logic          load;
    logic [7:0]    load_data;
    logic          found;
    logic [3:0]    pick;
    logic [4:0]    cand;
    logic [15:0]   pick_oh;
    logic [3:0]    next_ptr;

    assign valid16   = 16'(src_valid_i);
    assign data128   = 128'(src_data_i);
    assign free      = ~dst_valid_o | dst_ready_i;
    assign cur_valid = valid16[cur];
    assign cur_data  = data128[{cur, 3'b000} +: 8];
    assign pick_oh   = 16'd1 << pick;
    assign next_ptr  = (cur == LAST_SRC) ? 4'd0 : cur + 4'd1;

    // Search ptr, ptr+1, ... wrapping at SOURCES-1; first valid wins.
    always_comb begin
        found = 1'b0;
        pick  = 4'd0;
        cand  = 5'd0;
        for (int i = 0; i < SOURCES; i++) begin
            cand = {1'b0, ptr} + 5'(i);
            if (cand >= NSRC) cand = cand - NSRC;
            if (!found && valid16[cand[3:0]]) begin
                found = 1'b1;
                pick  = cand[3:0];
            end
        end
    end

    always_comb begin
        load      = 1'b0;
        load_data = cur_data;
        if (free) begin
            if (state == ST_HDR) begin
                load      = 1'b1;
                load_data = {HDR_TAG, cur};
            end else if (state == ST_BURST && cur_valid) begin
                load      = 1'b1;
            end
        end
    end

    assign src_ready_o = (state == ST_BURST && free) ? grant_o : '0;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state       <= ST_ARB;
            ptr         <= 4'd0;
            cur         <= 4'd0;
            count       <= '0;
            grant_o     <= '0;
            dst_valid_o <= 1'b0;
            dst_data_o  <= 8'h00;
        end else begin
            if (free) dst_valid_o <= load;
            if (load) dst_data_o  <= load_data;

            case (state)
                ST_ARB: begin
                    if (found) begin
                        grant_o <= pick_oh[SOURCES-1:0];
                        cur     <= pick;
                        count   <= '0;
                        state   <= (HEADER_EN != 0) ? ST_HDR
                                                    : ST_BURST;
                    end else begin
                        grant_o <= '0;
                    end
                end
                ST_HDR: begin
                    if (free) state <= ST_BURST;
                end
                ST_BURST: begin
                    // End decisions are only taken when the
                    // output register can move.
                    if (free) begin
                        if (cur_valid) begin
                            count <= count + CW'(1);
                            if (count == LAST_BYTE) begin
                                state   <= ST_ARB;
                                ptr     <= next_ptr;
                                grant_o <= '0;
                            end
                        end else begin
                            state   <= ST_ARB;
                            ptr     <= next_ptr;
                            grant_o <= '0;
                        end
                    end
                end
                default: begin
                    state   <= ST_ARB;
                    grant_o <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cdc_in_arbiter.sv
// tb_cdc_in_arbiter: scoreboard bench for cdc_in_arbiter (SOURCES=2).
// Source queues drive the inputs; a monitor pops expected bytes on handshakes.
module tb_cdc_in_arbiter;

    localparam int SOURCES = 2;

    logic                  clk;
    logic                  rst_i;
    logic [8*SOURCES-1:0]  src_data_i;
    logic [SOURCES-1:0]    src_valid_i;
    logic [SOURCES-1:0]    src_ready_o;
    logic [7:0]            dst_data_o;
    logic                  dst_valid_o;
    logic                  dst_ready_i;
    logic [SOURCES-1:0]    grant_o;

    logic [7:0] srcq0[$];
    logic [7:0] srcq1[$];
    logic [7:0] sb[$];

    int   pass_cnt  = 0;
    int   total_cnt = 0;
    int   rdy_mode  = 0;
    int   acc_cnt0  = 0;
    bit   rdy1_seen = 0;

    cdc_in_arbiter #(
        .SOURCES  (SOURCES),
        .MAX_BURST(8),
        .HEADER_EN(1),
        .HDR_TAG  (4'hA)
    ) dut (
        .clk_i      (clk),
        .rst_i      (rst_i),
        .src_data_i (src_data_i),
        .src_valid_i(src_valid_i),
        .src_ready_o(src_ready_o),
        .dst_data_o (dst_data_o),
        .dst_valid_o(dst_valid_o),
        .dst_ready_i(dst_ready_i),
        .grant_o    (grant_o)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name,
                         input logic [31:0] act,
                         input logic [31:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %0h expected %0h",
                      name, act, exp);
    endtask

    // Source driver: present queue heads at negedge, retire accepted bytes.
    initial begin
        src_valid_i = '0;
        src_data_i  = '0;
        dst_ready_i = 1'b0;
        forever begin
            @(negedge clk);
            src_valid_i[0]   = srcq0.size() > 0;
            src_data_i[7:0]  = (srcq0.size() > 0) ? srcq0[0] : 8'h00;
            src_valid_i[1]   = srcq1.size() > 0;
            src_data_i[15:8] = (srcq1.size() > 0) ? srcq1[0] : 8'h00;
            case (rdy_mode)
                0:       dst_ready_i = 1'b1;
                1:       dst_ready_i = 1'($urandom_range(0, 1));
                default: dst_ready_i = 1'b0;
            endcase
            #1;
            if (src_ready_o[1]) rdy1_seen = 1'b1;
            if (src_valid_i[0] && src_ready_o[0]) begin
                check("grant_src0", 32'(grant_o), 32'h1);
                void'(srcq0.pop_front());
                acc_cnt0++;
            end
            if (src_valid_i[1] && src_ready_o[1]) begin
                check("grant_src1", 32'(grant_o), 32'h2);
                void'(srcq1.pop_front());
            end
        end
    end

    // Output monitor: scoreboard pops and stall-stability checks.
    initial begin
        bit         prev_stall;
        logic [7:0] prev_data;
        logic [7:0] exp;
        prev_stall = 1'b0;
        prev_data  = 8'h00;
        forever begin
            @(negedge clk);
            #2;
            if (rst_i) begin
                prev_stall = 1'b0;
            end else begin
                if (prev_stall)
                    check("stall_hold",
                          32'({dst_valid_o, dst_data_o}),
                          32'({1'b1, prev_data}));
                if (dst_valid_o && dst_ready_i) begin
                    if (sb.size() == 0) begin
                        total_cnt++;
                        $display("FAIL dst_extra: got %0h expected none",
                                 dst_data_o);
                    end else begin
                        exp = sb.pop_front();
                        check("dst_byte", 32'(dst_data_o), 32'(exp));
                    end
                end
                prev_stall = dst_valid_o && !dst_ready_i;
                prev_data  = dst_data_o;
            end
        end
    end

    task automatic do_reset();
        @(negedge clk);
        #3;
        rst_i    = 1'b1;
        rdy_mode = 0;
        srcq0.delete();
        srcq1.delete();
        sb.delete();
        repeat (2) @(negedge clk);
        #3;
        rst_i = 1'b0;
    endtask

    task automatic drain(input string name);
        int n;
        n = 0;
        while ((sb.size() != 0 || srcq0.size() != 0 ||
                srcq1.size() != 0) && n < 3000) begin
            @(negedge clk);
            n++;
        end
        check({name, "_done"}, 32'(n < 3000), 32'h1);
        repeat (3) @(negedge clk);
        #3;
        check({name, "_idle"}, 32'({dst_valid_o, grant_o}), 32'h0);
    endtask

    task automatic push_sb(input logic [7:0] v, input int n);
        for (int i = 0; i < n; i++) sb.push_back(v);
    endtask

    initial begin
        int n;
        rst_i = 1'b1;

        // Reset with every source valid.
        for (int i = 0; i < 4; i++) begin
            srcq0.push_back(8'hEE);
            srcq1.push_back(8'hEE);
        end
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            #3;
            check("rst_outputs",
                  32'({dst_valid_o, grant_o, src_ready_o}), 32'h0);
        end
        do_reset();

        // Single source, 10 bytes: two bursts.
        rdy1_seen = 1'b0;
        for (int i = 1; i <= 10; i++) srcq0.push_back(8'(i));
        sb.push_back(8'hA0);
        for (int i = 1; i <= 8; i++) sb.push_back(8'(i));
        sb.push_back(8'hA0);
        sb.push_back(8'h09);
        sb.push_back(8'h0A);
        drain("single");
        check("src1_never_ready", 32'(rdy1_seen), 32'h0);

        // Round robin with both always valid.
        do_reset();
        for (int i = 0; i < 16; i++) begin
            srcq0.push_back(8'h11);
            srcq1.push_back(8'h22);
        end
        for (int r = 0; r < 2; r++) begin
            sb.push_back(8'hA0);
            push_sb(8'h11, 8);
            sb.push_back(8'hA1);
            push_sb(8'h22, 8);
        end
        drain("rr");

        // Random backpressure; order fixed by arbitration.
        do_reset();
        rdy_mode = 1;
        for (int i = 0; i < 12; i++) srcq0.push_back(8'h30 + 8'(i));
        for (int i = 0; i < 5; i++)  srcq1.push_back(8'h40 + 8'(i));
        sb.push_back(8'hA0);
        for (int i = 0; i < 8; i++)  sb.push_back(8'h30 + 8'(i));
        sb.push_back(8'hA1);
        for (int i = 0; i < 5; i++)  sb.push_back(8'h40 + 8'(i));
        sb.push_back(8'hA0);
        for (int i = 8; i < 12; i++) sb.push_back(8'h30 + 8'(i));
        drain("bp");
        rdy_mode = 0;

        // Short burst on src1, then src0 gets the next grant.
        do_reset();
        srcq1.push_back(8'h51);
        srcq1.push_back(8'h52);
        srcq1.push_back(8'h53);
        sb.push_back(8'hA1);
        sb.push_back(8'h51);
        sb.push_back(8'h52);
        sb.push_back(8'h53);
        sb.push_back(8'hA0);
        sb.push_back(8'h61);
        sb.push_back(8'h62);
        repeat (3) @(negedge clk);
        #3;
        srcq0.push_back(8'h61);
        srcq0.push_back(8'h62);
        drain("short");

        // Reset in the middle of a stalled burst.
        do_reset();
        acc_cnt0 = 0;
        for (int i = 1; i <= 8; i++) srcq0.push_back(8'h70 + 8'(i));
        sb.push_back(8'hA0);
        sb.push_back(8'h71);
        sb.push_back(8'h72);
        sb.push_back(8'h73);
        n = 0;
        while (acc_cnt0 < 4 && n < 100) begin
            @(posedge clk);
            n++;
        end
        check("mid_wait", 32'(n < 100), 32'h1);
        rdy_mode = 2;
        @(negedge clk);
        #3;
        rst_i = 1'b1;
        @(negedge clk);
        #3;
        check("mid_rst_outputs",
              32'({dst_valid_o, grant_o, src_ready_o}), 32'h0);
        check("mid_sb_empty", 32'(sb.size()), 32'h0);
        srcq0.delete();
        rdy_mode = 0;
        @(negedge clk);
        #3;
        rst_i = 1'b0;
        srcq0.push_back(8'h81);
        srcq0.push_back(8'h82);
        sb.push_back(8'hA0);
        sb.push_back(8'h81);
        sb.push_back(8'h82);
        drain("after_rst");

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
